// File: rtl/data_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter_if
// Brief    : Two-master / one-slave bus bundle for data_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface data_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req,    m1_req;
    logic              m0_we,     m1_we;
    logic [ADDR_W-1:0] m0_addr,   m1_addr;
    logic [DATA_W-1:0] m0_wdata,  m1_wdata;
    logic [2:0]        m0_funct3, m1_funct3;
    logic              m0_lock,   m1_lock;
    logic              m0_gnt,    m1_gnt;
    logic              m0_rvalid, m1_rvalid;
    logic [DATA_W-1:0] m0_rdata,  m1_rdata;
    logic              s_valid;
    logic              s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [2:0]        s_funct3;
    logic [DATA_W-1:0] s_rdata;

    // master: the arbiter, which drives the slave command bus.
    modport master (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
        input  m0_wdata, m1_wdata, m0_funct3, m1_funct3, m0_lock, m1_lock,
        input  s_rdata,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        output s_valid, s_we, s_addr, s_wdata, s_funct3
    );

    // slave: the surrounding masters and the slave device.
    modport slave (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
        output m0_wdata, m1_wdata, m0_funct3, m1_funct3, m0_lock, m1_lock,
        output s_rdata,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
        input  s_valid, s_we, s_addr, s_wdata, s_funct3
    );
endinterface
`default_nettype wire

// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Brief    : Two-master round-robin bus arbiter with bounded lock, 2-cycle ops.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    data_bus_arbiter_if.master bus
);
    localparam logic [0:0] c_IDLE     = 1'b0;
    localparam logic [0:0] c_RESP     = 1'b1;
    localparam logic [3:0] c_MAX_LOCK = 4'(MAX_LOCK);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic       r_owner;
    logic       r_lock;
    logic [3:0] r_cnt;
    logic       w_grant;
    logic       w_win;
    logic       w_resp;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (!rst && (bus.m0_req || bus.m1_req)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = c_RESP;
                    // Ties go to the locked owner until its streak hits the cap.
                    if (bus.m0_req && bus.m1_req)
                        w_win = (r_lock && (r_cnt < c_MAX_LOCK)) ? r_owner : ~r_owner;
                    else
                        w_win = bus.m1_req;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    assign w_resp = (r_state == c_RESP) && !rst;

    always_comb begin
        bus.m0_gnt    = w_grant & ~w_win;
        bus.m1_gnt    = w_grant &  w_win;
        bus.s_valid   = w_grant;
        bus.s_we      = 1'b0;
        bus.s_addr    = '0;
        bus.s_wdata   = '0;
        bus.s_funct3  = 3'b000;
        if (w_grant) begin
            bus.s_we     = w_win ? bus.m1_we     : bus.m0_we;
            bus.s_addr   = w_win ? bus.m1_addr   : bus.m0_addr;
            bus.s_wdata  = w_win ? bus.m1_wdata  : bus.m0_wdata;
            bus.s_funct3 = w_win ? bus.m1_funct3 : bus.m0_funct3;
        end
        bus.m0_rvalid = w_resp & ~r_owner;
        bus.m1_rvalid = w_resp &  r_owner;
        bus.m0_rdata  = (w_resp & ~r_owner) ? bus.s_rdata : '0;
        bus.m1_rdata  = (w_resp &  r_owner) ? bus.s_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_owner <= 1'b1;
            r_lock  <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_win;
                r_lock  <= w_win ? bus.m1_lock : bus.m0_lock;
                if (w_win == r_owner)
                    r_cnt <= (r_cnt >= c_MAX_LOCK) ? c_MAX_LOCK : r_cnt + 4'd1;
                else
                    r_cnt <= 4'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Brief    : Cycle-vector table with read-data scoreboard for data_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;
    localparam int          c_AW = 32;
    localparam int          c_DW = 32;
    localparam logic [31:0] c_A0 = 32'h0000_0100;
    localparam logic [31:0] c_A1 = 32'h8000_1000;
    localparam logic [31:0] c_D0 = 32'h0000_A5A5;
    localparam logic [31:0] c_D1 = 32'h0000_0001;
    localparam logic [2:0]  c_F0 = 3'b100;
    localparam logic [2:0]  c_F1 = 3'b010;

    logic clk;
    logic rst;

    data_bus_arbiter_if #(.ADDR_W(c_AW), .DATA_W(c_DW)) bus ();

    data_bus_arbiter #(.ADDR_W(c_AW), .DATA_W(c_DW), .MAX_LOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bit 1 = m1, bit 0 = m0
    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] lock;
        logic [1:0] we;
        logic [1:0] gnt;
        logic [1:0] rv;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_push   = 0;
    int          cur      = 0;

    function automatic vec_t mk(logic r, logic [1:0] req, logic [1:0] lock,
                                logic [1:0] we, logic [1:0] gnt, logic [1:0] rv);
        vec_t v;
        v.rst = r; v.req = req; v.lock = lock; v.we = we; v.gnt = gnt; v.rv = rv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @vec%0d: got %h, want %h", name, cur, act, exp);
    endtask

    task automatic drive(input vec_t v);
        rst           = v.rst;
        bus.m0_req    = v.req[0];  bus.m1_req  = v.req[1];
        bus.m0_lock   = v.lock[0]; bus.m1_lock = v.lock[1];
        bus.m0_we     = v.we[0];   bus.m1_we   = v.we[1];
    endtask

    task automatic check_vec(input vec_t v);
        logic        w;
        logic [31:0] e;
        w = v.gnt[1];
        chk("m0_gnt",    64'(bus.m0_gnt),    64'(v.gnt[0]));
        chk("m1_gnt",    64'(bus.m1_gnt),    64'(v.gnt[1]));
        chk("s_valid",   64'(bus.s_valid),   64'(|v.gnt));
        chk("s_we",      64'(bus.s_we),      64'((|v.gnt) & v.we[w]));
        chk("s_addr",    64'(bus.s_addr),    64'((|v.gnt) ? (w ? c_A1 : c_A0) : 32'h0));
        chk("s_wdata",   64'(bus.s_wdata),   64'((|v.gnt) ? (w ? c_D1 : c_D0) : 32'h0));
        chk("s_funct3",  64'(bus.s_funct3),  64'((|v.gnt) ? (w ? c_F1 : c_F0) : 3'b000));
        chk("m0_rvalid", 64'(bus.m0_rvalid), 64'(v.rv[0]));
        chk("m1_rvalid", 64'(bus.m1_rvalid), 64'(v.rv[1]));
        if (|v.rv) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 64'(0), 64'(1));
            end else begin
                e = exp_q.pop_front();
                chk("owner_rdata", 64'(v.rv[1] ? bus.m1_rdata : bus.m0_rdata), 64'(e));
                chk("other_rdata", 64'(v.rv[1] ? bus.m0_rdata : bus.m1_rdata), 64'(0));
            end
        end else begin
            chk("m0_rdata", 64'(bus.m0_rdata), 64'(0));
            chk("m1_rdata", 64'(bus.m1_rdata), 64'(0));
        end
        if (|v.gnt) begin
            exp_q.push_back((w ? 32'h5A00_0000 : 32'hDEAD_BEEF) + 32'(n_push * 257));
            n_push++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic got;
        rst = 1'b1;
        bus.m0_req = 0; bus.m1_req = 0; bus.m0_lock = 0; bus.m1_lock = 0;
        bus.m0_we = 0;  bus.m1_we = 0;
        bus.m0_addr = c_A0;  bus.m1_addr = c_A1;
        bus.m0_wdata = c_D0; bus.m1_wdata = c_D1;
        bus.m0_funct3 = c_F0; bus.m1_funct3 = c_F1;
        bus.s_rdata = 32'h0;

        // reset state and single read of 0x100
        tbl.push_back(mk(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
        // round-robin ties after reset
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, (k % 2) ? 2'b10 : 2'b01, 2'b00));
            tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b00, (k % 2) ? 2'b10 : 2'b01));
        end
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // m1 lock: m0, then m1 x4, then m0, then plain round-robin
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01));
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00));
            tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10));
        end
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01));
        // m1 write acknowledge
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10));
        // m1 request rising during m0 RESP
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
        // reset during RESP aborts; next tie to m0
        tbl.push_back(mk(0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00));
        // m1 request dropped before grant is never served
        tbl.push_back(mk(0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        tbl.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            cur = i;
            drive(tbl[i]);
            if (tbl[i].rst) exp_q.delete();
            bus.s_rdata = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
            #3;
            check_vec(tbl[i]);
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        // asynchronous reset mid-cycle kills a combinational grant at once
        cur = 1000;
        @(posedge clk); #1;
        rst = 1'b0; bus.m0_req = 1'b1; bus.s_rdata = 32'h0;
        #1;
        chk("pre_async_gnt", 64'(bus.m0_gnt), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_gnt",    64'(bus.m0_gnt),  64'(0));
        chk("async_rst_svalid", 64'(bus.s_valid), 64'(0));
        chk("async_rst_saddr",  64'(bus.s_addr),  64'(0));

        // release reset with m0 still requesting; grant within a bounded wait
        @(posedge clk); #1;
        rst = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 5 && !got; k++) begin
            #1;
            if (bus.m0_gnt) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("bounded_gnt", 64'(got), 64'(1));
        @(posedge clk); #1;
        bus.m0_req  = 1'b0;
        bus.s_rdata = 32'h0BAD_F00D;
        #2;
        chk("late_rvalid", 64'(bus.m0_rvalid), 64'(1));
        chk("late_rdata",  64'(bus.m0_rdata),  64'(32'h0BAD_F00D));
        chk("late_gnt",    64'(bus.m1_gnt | bus.m0_gnt), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
